// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute sequencer driving the DataPath control lines.
// State is registered; strobes are a combinational decode of state and ir, forced low while clr is high.
module control_sequencer #(
  parameter logic [4:0] PC_INC_OP = 5'b11111,
  parameter int         CNT_W     = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [31:0]      ir,
  output logic             run,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count,
  output logic             Pout,
  output logic             MARen,
  output logic             Pen,
  output logic             Read,
  output logic             MDRen,
  output logic             MDROut,
  output logic             IRen,
  output logic             Yen,
  output logic             ZLOen,
  output logic             ZHIen,
  output logic             ZLOout,
  output logic             ZHIout,
  output logic             LOen,
  output logic             HIen,
  output logic [15:0]      reg_out,
  output logic [15:0]      reg_en,
  output logic [4:0]       alu_control
);

  typedef enum logic [3:0] {
    T0     = 4'b0111,
    T1     = 4'b1000,
    T2     = 4'b1001,
    T3     = 4'b1010,
    T4     = 4'b1011,
    T5     = 4'b1100,
    T6     = 4'b1101,
    HALTED = 4'b1111
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;

  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  logic       is_bin, is_md, is_un, is_halt;

  assign op = ir[31:27];
  assign ra = ir[26:23];
  assign rb = ir[22:19];
  assign rc = ir[18:15];

  assign is_bin  = (op >= 5'b00011) && (op <= 5'b01010);
  assign is_md   = (op == 5'b01111) || (op == 5'b10000);
  assign is_un   = (op == 5'b10001) || (op == 5'b10010);
  assign is_halt = (op == 5'b11010);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= T0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == T2) begin
        cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    Pout        = 1'b0;
    MARen       = 1'b0;
    Pen         = 1'b0;
    Read        = 1'b0;
    MDRen       = 1'b0;
    MDROut      = 1'b0;
    IRen        = 1'b0;
    Yen         = 1'b0;
    ZLOen       = 1'b0;
    ZHIen       = 1'b0;
    ZLOout      = 1'b0;
    ZHIout      = 1'b0;
    LOen        = 1'b0;
    HIen        = 1'b0;
    reg_out     = 16'h0000;
    reg_en      = 16'h0000;
    alu_control = 5'b00000;
    // clr kills every strobe in the same cycle, not just at the next edge
    if (!clr) begin
      unique case (state_q)
        T0: begin
          Pout = 1'b1; MARen = 1'b1; ZLOen = 1'b1;
          alu_control = PC_INC_OP;
          state_d = T1;
        end
        T1: begin
          ZLOout = 1'b1; Pen = 1'b1; Read = 1'b1; MDRen = 1'b1;
          state_d = T2;
        end
        T2: begin
          MDROut = 1'b1; IRen = 1'b1;
          state_d = T3;
        end
        T3: begin
          if (is_bin || is_md) begin
            reg_out = 16'd1 << rb; Yen = 1'b1;
            state_d = T4;
          end else if (is_un) begin
            reg_out = 16'd1 << rb; alu_control = op; ZLOen = 1'b1;
            state_d = T4;
          end else if (is_halt) begin
            state_d = HALTED;
          end else begin
            state_d = T0;
          end
        end
        T4: begin
          if (is_bin || is_md) begin
            reg_out = 16'd1 << rc; alu_control = op; ZLOen = 1'b1;
            ZHIen = is_md;
            state_d = T5;
          end else if (is_un) begin
            ZLOout = 1'b1; reg_en = 16'd1 << ra;
            state_d = T0;
          end else begin
            state_d = T0;
          end
        end
        T5: begin
          ZLOout = 1'b1;
          if (is_md) begin
            LOen = 1'b1;
            state_d = T6;
          end else begin
            reg_en = 16'd1 << ra;
            state_d = T0;
          end
        end
        T6: begin
          ZHIout = 1'b1; HIen = 1'b1;
          state_d = T0;
        end
        HALTED: state_d = HALTED;
        default: state_d = T0;
      endcase
    end
  end

  assign state       = state_q;
  assign run         = (state_q != HALTED);
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: cycle-exact strobe checks per instruction class, halt, clr abort and counter wrap.
module tb_control_sequencer;

  localparam logic [3:0] ST_T0 = 4'b0111, ST_T1 = 4'b1000, ST_T2 = 4'b1001, ST_T3 = 4'b1010;
  localparam logic [3:0] ST_T4 = 4'b1011, ST_T5 = 4'b1100, ST_T6 = 4'b1101, ST_HALT = 4'b1111;

  // strobe vector order: Pout MARen Pen Read MDRen MDROut IRen Yen ZLOen ZHIen ZLOout ZHIout LOen HIen
  localparam logic [13:0] S_POUT = 14'h2000, S_MAREN = 14'h1000, S_PEN = 14'h0800, S_READ = 14'h0400;
  localparam logic [13:0] S_MDREN = 14'h0200, S_MDROUT = 14'h0100, S_IREN = 14'h0080, S_YEN = 14'h0040;
  localparam logic [13:0] S_ZLOEN = 14'h0020, S_ZHIEN = 14'h0010, S_ZLOOUT = 14'h0008, S_ZHIOUT = 14'h0004;
  localparam logic [13:0] S_LOEN = 14'h0002, S_HIEN = 14'h0001;

  logic        clk, clr;
  logic [31:0] ir;
  logic        run;
  logic [3:0]  state;
  logic [15:0] instr_count;
  logic        Pout, MARen, Pen, Read, MDRen, MDROut, IRen, Yen;
  logic        ZLOen, ZHIen, ZLOout, ZHIout, LOen, HIen;
  logic [15:0] reg_out, reg_en;
  logic [4:0]  alu_control;

  logic        s_run;
  logic [3:0]  s_state;
  logic [3:0]  s_cnt;
  logic        s_Pout, s_MARen, s_Pen, s_Read, s_MDRen, s_MDROut, s_IRen, s_Yen;
  logic        s_ZLOen, s_ZHIen, s_ZLOout, s_ZHIout, s_LOen, s_HIen;
  logic [15:0] s_reg_out, s_reg_en;
  logic [4:0]  s_alu;

  int          compared   = 0;
  int          mismatched = 0;
  logic [15:0] exp_cnt;

  control_sequencer dut (
    .clk(clk), .clr(clr), .ir(ir), .run(run), .state(state), .instr_count(instr_count),
    .Pout(Pout), .MARen(MARen), .Pen(Pen), .Read(Read), .MDRen(MDRen), .MDROut(MDROut),
    .IRen(IRen), .Yen(Yen), .ZLOen(ZLOen), .ZHIen(ZHIen), .ZLOout(ZLOout), .ZHIout(ZHIout),
    .LOen(LOen), .HIen(HIen), .reg_out(reg_out), .reg_en(reg_en), .alu_control(alu_control)
  );

  // narrow-counter copy so the wrap can be reached in a few dozen instructions
  control_sequencer #(.CNT_W(4)) dut_small (
    .clk(clk), .clr(clr), .ir(ir), .run(s_run), .state(s_state), .instr_count(s_cnt),
    .Pout(s_Pout), .MARen(s_MARen), .Pen(s_Pen), .Read(s_Read), .MDRen(s_MDRen), .MDROut(s_MDROut),
    .IRen(s_IRen), .Yen(s_Yen), .ZLOen(s_ZLOen), .ZHIen(s_ZHIen), .ZLOout(s_ZLOout), .ZHIout(s_ZHIout),
    .LOen(s_LOen), .HIen(s_HIen), .reg_out(s_reg_out), .reg_en(s_reg_en), .alu_control(s_alu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [13:0] strobes();
    return {Pout, MARen, Pen, Read, MDRen, MDROut, IRen, Yen, ZLOen, ZHIen, ZLOout, ZHIout, LOen, HIen};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // check the current cycle (inputs already driven at the falling edge), then advance one cycle
  task automatic step(input string tag, input logic [3:0] st, input logic [13:0] strb,
                      input logic [15:0] ro, input logic [15:0] re, input logic [4:0] alu);
    #1;
    chk({tag, ".state"}, 32'(state), 32'(st));
    chk({tag, ".strb"}, 32'(strobes()), 32'(strb));
    chk({tag, ".reg_out"}, 32'(reg_out), 32'(ro));
    chk({tag, ".reg_en"}, 32'(reg_en), 32'(re));
    chk({tag, ".alu"}, 32'(alu_control), 32'(alu));
    chk({tag, ".run"}, 32'(run), 32'(st != ST_HALT));
    chk({tag, ".cnt"}, 32'(instr_count), 32'(exp_cnt));
    @(negedge clk);
    if (st == ST_T2) exp_cnt = exp_cnt + 16'd1;
  endtask

  task automatic fetch(input string tag);
    step({tag, ".T0"}, ST_T0, S_POUT | S_MAREN | S_ZLOEN, 16'h0, 16'h0, 5'b11111);
    step({tag, ".T1"}, ST_T1, S_ZLOOUT | S_PEN | S_READ | S_MDREN, 16'h0, 16'h0, 5'b0);
    step({tag, ".T2"}, ST_T2, S_MDROUT | S_IREN, 16'h0, 16'h0, 5'b0);
  endtask

  initial begin
    clr = 1'b0;
    ir  = 32'h0;
    exp_cnt = 16'h0;
    #2 clr = 1'b1;
    @(negedge clk);
    #1;
    chk("reset.state", 32'(state), 32'(ST_T0));
    chk("reset.strb", 32'(strobes()), 32'h0);
    chk("reset.reg_out", 32'(reg_out), 32'h0);
    chk("reset.reg_en", 32'(reg_en), 32'h0);
    chk("reset.alu", 32'(alu_control), 32'h0);
    chk("reset.run", 32'(run), 32'h1);
    chk("reset.cnt", 32'(instr_count), 32'h0);
    chk("reset.small_cnt", 32'(s_cnt), 32'h0);
    @(negedge clk);
    clr = 1'b0;

    // ir=0: undefined opcode behaves as nop
    fetch("zero");
    step("zero.T3", ST_T3, 14'h0, 16'h0, 16'h0, 5'b0);

    // and R1,R2,R3
    ir = 32'h28918000;
    fetch("and");
    step("and.T3", ST_T3, S_YEN, 16'h0004, 16'h0, 5'b0);
    step("and.T4", ST_T4, S_ZLOEN, 16'h0008, 16'h0, 5'b00101);
    step("and.T5", ST_T5, S_ZLOOUT, 16'h0, 16'h0002, 5'b0);

    // mul R3,R4,R5: seven cycles
    ir = {5'b01111, 4'd3, 4'd4, 4'd5, 15'd0};
    fetch("mul");
    step("mul.T3", ST_T3, S_YEN, 16'h0010, 16'h0, 5'b0);
    step("mul.T4", ST_T4, S_ZLOEN | S_ZHIEN, 16'h0020, 16'h0, 5'b01111);
    step("mul.T5", ST_T5, S_ZLOOUT | S_LOEN, 16'h0, 16'h0, 5'b0);
    step("mul.T6", ST_T6, S_ZHIOUT | S_HIEN, 16'h0, 16'h0, 5'b0);

    // neg R7,R6: five cycles
    ir = {5'b10001, 4'd7, 4'd6, 4'd0, 15'd0};
    fetch("neg");
    step("neg.T3", ST_T3, S_ZLOEN, 16'h0040, 16'h0, 5'b10001);
    step("neg.T4", ST_T4, S_ZLOOUT, 16'h0, 16'h0080, 5'b0);

    // undefined opcode 10111
    ir = {5'b10111, 4'd7, 4'd6, 4'd0, 15'd0};
    fetch("undef");
    step("undef.T3", ST_T3, 14'h0, 16'h0, 16'h0, 5'b0);

    // shl R0,R0,R15: register-index extremes, destination equals a source
    ir = {5'b01000, 4'd0, 4'd0, 4'd15, 15'd0};
    fetch("shl");
    step("shl.T3", ST_T3, S_YEN, 16'h0001, 16'h0, 5'b0);
    step("shl.T4", ST_T4, S_ZLOEN, 16'h8000, 16'h0, 5'b01000);
    step("shl.T5", ST_T5, S_ZLOOUT, 16'h0, 16'h0001, 5'b0);

    // clr during T4 of an add abandons it with no write-back
    ir = {5'b00011, 4'd2, 4'd3, 4'd4, 15'd0};
    fetch("abort");
    step("abort.T3", ST_T3, S_YEN, 16'h0008, 16'h0, 5'b0);
    #1;
    chk("abort.T4.state", 32'(state), 32'(ST_T4));
    chk("abort.T4.reg_out", 32'(reg_out), 32'h0010);
    clr = 1'b1;
    exp_cnt = 16'h0;
    #1;
    chk("abort.clr.state", 32'(state), 32'(ST_T0));
    chk("abort.clr.strb", 32'(strobes()), 32'h0);
    chk("abort.clr.reg_out", 32'(reg_out), 32'h0);
    chk("abort.clr.reg_en", 32'(reg_en), 32'h0);
    chk("abort.clr.alu", 32'(alu_control), 32'h0);
    chk("abort.clr.cnt", 32'(instr_count), 32'h0);
    @(negedge clk);
    #1;
    chk("abort.hold.reg_en", 32'(reg_en), 32'h0);
    @(negedge clk);
    clr = 1'b0;

    // halt: frozen for 20 clocks, then clr restarts
    ir = {5'b11010, 27'd0};
    fetch("halt");
    step("halt.T3", ST_T3, 14'h0, 16'h0, 16'h0, 5'b0);
    for (int i = 0; i < 20; i++) begin
      step("halt.hold", ST_HALT, 14'h0, 16'h0, 16'h0, 5'b0);
    end
    clr = 1'b1;
    exp_cnt = 16'h0;
    #1;
    chk("halt.clr.run", 32'(run), 32'h1);
    chk("halt.clr.cnt", 32'(instr_count), 32'h0);
    chk("halt.clr.state", 32'(state), 32'(ST_T0));
    @(negedge clk);
    clr = 1'b0;

    // counter wrap, observed on the 4-bit instance (15 -> 0) and the 16-bit one carrying on
    ir = {5'b11001, 27'd0};
    for (int n = 0; n < 15; n++) begin
      fetch("nop");
      step("nop.T3", ST_T3, 14'h0, 16'h0, 16'h0, 5'b0);
    end
    #1;
    chk("wrap.small_pre", 32'(s_cnt), 32'hF);
    chk("wrap.main_pre", 32'(instr_count), 32'd15);
    fetch("nop_last");
    step("nop_last.T3", ST_T3, 14'h0, 16'h0, 16'h0, 5'b0);
    #1;
    chk("wrap.small_post", 32'(s_cnt), 32'h0);
    chk("wrap.main_post", 32'(instr_count), 32'd16);
    chk("wrap.state", 32'(state), 32'(ST_T0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
